// File: rtl/flash_boot_pkg.sv
// Shared types and constants for the flash-to-IMEM boot copy controller.
package flash_boot_pkg;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, WRITE, DONE} state_e;

  localparam logic [7:0] READ_CMD  = 8'h03;
  localparam int         CMD_BITS  = 8;
  localparam int         ADDR_BITS = 24;
  localparam int         WORD_BITS = 32;
  localparam int         BIT_CNT_W = $clog2(WORD_BITS);

  // Flash bytes arrive in address order; the first byte is the least significant.
  function automatic logic [WORD_BITS-1:0] byte_swap(input logic [WORD_BITS-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0 SPI bit engine: clock divider, bit counter, TX/RX shift registers.
module spi_shift_engine
  import flash_boot_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 en,
  input  logic [WORD_BITS-1:0] tx_data,
  input  logic                 miso,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 running,
  output logic                 bit_done,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic [WORD_BITS-1:0] rx_data
);

  logic [7:0]           div_cnt;
  logic [WORD_BITS-1:0] tx_sr;
  logic                 phase_end;

  assign phase_end = running && en && (div_cnt == 8'(CLK_DIV - 1));
  assign bit_done  = phase_end && sclk;
  assign mosi      = tx_sr[WORD_BITS-1];

  always_ff @(posedge clock) begin
    if (!reset) begin
      running <= 1'b0;
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      running <= 1'b1;
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (phase_end) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
      if (sclk) bit_cnt <= bit_cnt + 1'b1;
    end else if (running && en) begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // Sample on the rising edge, advance MOSI on the falling edge.
  always_ff @(posedge clock) begin
    if (load) begin
      tx_sr <= tx_data;
    end else if (phase_end) begin
      if (!sclk) rx_data <= {rx_data[WORD_BITS-2:0], miso};
      else       tx_sr   <= {tx_sr[WORD_BITS-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/flash_boot_ctrl.sv
// Boot controller: reads WORD_COUNT words from SPI flash and writes them to IMEM.
module flash_boot_ctrl
  import flash_boot_pkg::*;
#(
  parameter int          CLK_DIV    = 4,
  parameter int          WORD_COUNT = 256,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter logic [31:0] IMEM_BASE  = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        spi_cs,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  input  logic        imem_ready,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] LAST_WORD = 16'(WORD_COUNT - 1);

  state_e               state, state_nxt;
  logic [15:0]          word_cnt;
  logic                 eng_load, eng_en, eng_mosi, eng_running, bit_done;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [WORD_BITS-1:0] rx_data;

  spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clock   (clock),
    .reset   (reset),
    .load    (eng_load),
    .en      (eng_en),
    .tx_data ({READ_CMD, FLASH_BASE}),
    .miso    (spi_miso),
    .sclk    (spi_clk),
    .mosi    (eng_mosi),
    .running (eng_running),
    .bit_done(bit_done),
    .bit_cnt (bit_cnt),
    .rx_data (rx_data)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // The bit counter wraps every 32 bits, so CMD+ADDR and each DATA word end at 31.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CMD;
      CMD:     if (bit_done && bit_cnt == BIT_CNT_W'(CMD_BITS - 1)) state_nxt = ADDR;
      ADDR:    if (bit_done && bit_cnt == BIT_CNT_W'(CMD_BITS + ADDR_BITS - 1)) state_nxt = DATA;
      DATA:    if (bit_done && bit_cnt == BIT_CNT_W'(WORD_BITS - 1)) state_nxt = WRITE;
      WRITE:   if (imem_ready) state_nxt = (word_cnt == LAST_WORD) ? DONE : DATA;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // The first CMD cycle loads the engine, which gives the extra start-to-stream cycle.
  always_comb begin
    spi_cs   = 1'b1;
    spi_mosi = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    cpu_hold = 1'b1;
    imem_we  = 1'b0;
    eng_en   = 1'b0;
    eng_load = 1'b0;
    case (state)
      CMD: begin
        spi_cs   = 1'b0;
        busy     = 1'b1;
        spi_mosi = eng_running & eng_mosi;
        eng_en   = 1'b1;
        eng_load = ~eng_running;
      end
      ADDR: begin
        spi_cs   = 1'b0;
        busy     = 1'b1;
        spi_mosi = eng_mosi;
        eng_en   = 1'b1;
      end
      DATA: begin
        spi_cs = 1'b0;
        busy   = 1'b1;
        eng_en = 1'b1;
      end
      WRITE: begin
        spi_cs  = 1'b0;
        busy    = 1'b1;
        imem_we = 1'b1;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      word_cnt   <= '0;
      imem_addr  <= IMEM_BASE;
      imem_wdata <= '0;
    end else begin
      if (state == DATA && state_nxt == WRITE) imem_wdata <= byte_swap(rx_data);
      if (state == WRITE && imem_ready) begin
        imem_addr <= imem_addr + 32'd4;
        word_cnt  <= word_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_flash_boot_ctrl.sv
// Scoreboard bench: flash model drives MISO, monitors pop expected IMEM writes.
module tb_flash_boot_ctrl;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        imem_ready_a = 1'b1;
  logic        spi_miso_a = 1'b0;
  logic        spi_cs_a, spi_clk_a, spi_mosi_a, imem_we_a, cpu_hold_a, busy_a, done_a;
  logic [31:0] imem_addr_a, imem_wdata_a;
  logic        imem_ready_b, spi_miso_b;
  logic        spi_cs_b, spi_clk_b, spi_mosi_b, imem_we_b, cpu_hold_b, busy_b, done_b;
  logic [31:0] imem_addr_b, imem_wdata_b;

  assign imem_ready_b = 1'b1;
  assign spi_miso_b   = 1'b1;

  flash_boot_ctrl #(.CLK_DIV(4), .WORD_COUNT(4), .FLASH_BASE(24'h001000), .IMEM_BASE(32'h0)) dut_a (
    .clock(clock), .reset(reset), .start(start_a),
    .spi_cs(spi_cs_a), .spi_clk(spi_clk_a), .spi_mosi(spi_mosi_a), .spi_miso(spi_miso_a),
    .imem_we(imem_we_a), .imem_addr(imem_addr_a), .imem_wdata(imem_wdata_a), .imem_ready(imem_ready_a),
    .cpu_hold(cpu_hold_a), .busy(busy_a), .done(done_a)
  );

  flash_boot_ctrl #(.CLK_DIV(2), .WORD_COUNT(2), .FLASH_BASE(24'h000000), .IMEM_BASE(32'hFFFFFFFC)) dut_b (
    .clock(clock), .reset(reset), .start(start_b),
    .spi_cs(spi_cs_b), .spi_clk(spi_clk_b), .spi_mosi(spi_mosi_b), .spi_miso(spi_miso_b),
    .imem_we(imem_we_b), .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b), .imem_ready(imem_ready_b),
    .cpu_hold(cpu_hold_b), .busy(busy_b), .done(done_b)
  );

  always #5 clock = ~clock;

  int  checks = 0;
  int  passed = 0;
  wr_t exp_a[$];
  wr_t exp_b[$];
  wr_t ea, eb;
  int  writes_a = 0;
  int  writes_b = 0;

  logic [31:0] flash_words [4] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0000006F};
  int          fcnt = 0;
  logic [31:0] cmd_cap = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic data_bit(input int j);
    int k;
    int w;
    k = j / 8;
    w = (k / 4) % 4;
    return flash_words[w][8 * (k % 4) + 7 - (j % 8)];
  endfunction

  // Flash model: stream restarts whenever chip select is released.
  always @(posedge spi_cs_a) fcnt = 0;
  always @(posedge spi_clk_a) begin
    if (spi_cs_a === 1'b0) begin
      if (fcnt < 32) cmd_cap = {cmd_cap[30:0], spi_mosi_a};
      fcnt++;
    end
  end
  always @(negedge spi_clk_a) begin
    if (spi_cs_a === 1'b0 && fcnt >= 32) spi_miso_a = data_bit(fcnt - 32);
  end

  always @(negedge clock) begin
    if (reset && imem_we_a === 1'b1 && imem_ready_a) begin
      writes_a++;
      if (exp_a.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write_a: got addr %h data %h expected no write", imem_addr_a, imem_wdata_a);
      end else begin
        ea = exp_a.pop_front();
        chk("wr_addr_a", imem_addr_a, ea.addr);
        chk("wr_data_a", imem_wdata_a, ea.data);
      end
    end
  end

  always @(negedge clock) begin
    if (reset && imem_we_b === 1'b1 && imem_ready_b) begin
      writes_b++;
      if (exp_b.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write_b: got addr %h data %h expected no write", imem_addr_b, imem_wdata_b);
      end else begin
        eb = exp_b.pop_front();
        chk("wr_addr_b", imem_addr_b, eb.addr);
        chk("wr_data_b", imem_wdata_b, eb.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    int          wbase;
    logic [31:0] sa, sd;
    logic        stable;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_cs", spi_cs_a, 1);
    chk("rst_sclk", spi_clk_a, 0);
    chk("rst_mosi", spi_mosi_a, 0);
    chk("rst_we", imem_we_a, 0);
    chk("rst_addr", imem_addr_a, 32'h0);
    chk("rst_wdata", imem_wdata_a, 32'h0);
    chk("rst_hold", cpu_hold_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_addr_b", imem_addr_b, 32'hFFFFFFFC);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Run 1: first write stalled for 10 cycles, start pulsed mid-copy and in DONE.
    imem_ready_a = 1'b0;
    for (int i = 0; i < 4; i++) exp_a.push_back('{addr: 32'(4 * i), data: flash_words[i]});
    start_a = 1'b1;
    @(posedge clock);
    #1;
    start_a = 1'b0;
    chk("start_cs", spi_cs_a, 0);
    chk("start_busy", busy_a, 1);
    n = 0;
    while (imem_we_a !== 1'b1 && n < 2000) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("first_we_latency", 32'(n), 32'd513);
    chk("cmd_addr_bits", cmd_cap, 32'h03001000);
    sa = imem_addr_a;
    sd = imem_wdata_a;
    stable = 1'b1;
    repeat (10) begin
      @(posedge clock);
      #1;
      if (!(imem_we_a === 1'b1 && imem_addr_a === sa && imem_wdata_a === sd && spi_clk_a === 1'b0))
        stable = 1'b0;
    end
    chk("stall_stable", {31'b0, stable}, 1);
    imem_ready_a = 1'b1;
    n = 0;
    while (writes_a < 1 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    repeat (20) @(posedge clock);
    #1;
    start_a = 1'b1;
    @(posedge clock);
    #1;
    start_a = 1'b0;
    chk("start_in_data_busy", busy_a, 1);
    chk("start_in_data_cs", spi_cs_a, 0);
    n = 0;
    while (done_a !== 1'b1 && n < 5000) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("done_reached", done_a, 1);
    chk("done_writes", 32'(writes_a), 32'd4);
    chk("done_hold", cpu_hold_a, 0);
    chk("done_cs", spi_cs_a, 1);
    chk("done_busy", busy_a, 0);
    chk("done_queue_empty", 32'(exp_a.size()), 32'd0);
    start_a = 1'b1;
    @(posedge clock);
    #1;
    start_a = 1'b0;
    repeat (50) @(posedge clock);
    #1;
    chk("done_sticky", done_a, 1);
    chk("done_sticky_busy", busy_a, 0);
    chk("done_sticky_writes", 32'(writes_a), 32'd4);

    // Run 2: abort during word 2, then recopy from the base address.
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    chk("rerst_addr", imem_addr_a, 32'h0);
    chk("rerst_done", done_a, 0);
    wbase = writes_a;
    for (int i = 0; i < 4; i++) exp_a.push_back('{addr: 32'(4 * i), data: flash_words[i]});
    start_a = 1'b1;
    @(posedge clock);
    #1;
    start_a = 1'b0;
    n = 0;
    while (writes_a < wbase + 1 && n < 2000) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("abort_first_write", 32'(writes_a - wbase), 32'd1);
    repeat (30) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    chk("abort_cs", spi_cs_a, 1);
    chk("abort_hold", cpu_hold_a, 1);
    chk("abort_we", imem_we_a, 0);
    chk("abort_sclk", spi_clk_a, 0);
    chk("abort_addr", imem_addr_a, 32'h0);
    exp_a.delete();
    wbase = writes_a;
    repeat (200) @(posedge clock);
    #1;
    chk("abort_no_writes", 32'(writes_a), 32'(wbase));
    for (int i = 0; i < 4; i++) exp_a.push_back('{addr: 32'(4 * i), data: flash_words[i]});
    start_a = 1'b1;
    @(posedge clock);
    #1;
    start_a = 1'b0;
    n = 0;
    while (done_a !== 1'b1 && n < 5000) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("recopy_done", done_a, 1);
    chk("recopy_writes", 32'(writes_a - wbase), 32'd4);
    chk("recopy_queue_empty", 32'(exp_a.size()), 32'd0);

    // Address wrap and single-cycle handshake on the second instance.
    exp_b.push_back('{addr: 32'hFFFFFFFC, data: 32'hFFFFFFFF});
    exp_b.push_back('{addr: 32'h00000000, data: 32'hFFFFFFFF});
    start_b = 1'b1;
    @(posedge clock);
    #1;
    start_b = 1'b0;
    n = 0;
    while (imem_we_b !== 1'b1 && n < 2000) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("first_we_latency_b", 32'(n), 32'd257);
    n = 0;
    while (done_b !== 1'b1 && n < 2000) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("done_b", done_b, 1);
    chk("writes_b", 32'(writes_b), 32'd2);
    chk("queue_b_empty", 32'(exp_b.size()), 32'd0);
    chk("wrap_addr_b", imem_addr_b, 32'h00000004);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/flash_boot_ctrl.md
FLASH_BOOT_CTRL -- requirements
Module: flash_boot_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SPI half-period in clock cycles, legal range 2..255.
REQ-002 SHALL have parameter WORD_COUNT, default 256: number of 32-bit words copied, legal range 1..65535.
REQ-003 SHALL have parameter FLASH_BASE, default 24'h000000: start byte address in flash.
REQ-004 SHALL have parameter IMEM_BASE, default 32'h0: first instruction-memory byte address.
REQ-005 SHALL have port clock, input, 1: single clock; all logic rises on it.
REQ-006 SHALL have port reset, input, 1: synchronous, active-low (reset==0 resets on the next clock edge).
REQ-007 SHALL have port start, input, 1: begin boot copy.
REQ-008 SHALL have port spi_cs, output, 1: flash chip select, active-low.
REQ-009 SHALL have port spi_clk, output, 1: SPI clock, mode 0.
REQ-010 SHALL have port spi_mosi, output, 1: command and address to flash.
REQ-011 SHALL have port spi_miso, input, 1: data from flash.
REQ-012 SHALL have port imem_we, output, 1: instruction-memory write request.
REQ-013 SHALL have port imem_addr, output, 32: write byte address.
REQ-014 SHALL have port imem_wdata, output, 32: write data.
REQ-015 SHALL have port imem_ready, input, 1: write accepted.
REQ-016 SHALL have port cpu_hold, output, 1: keeps the core stalled while high.
REQ-017 SHALL have ports busy and done, outputs, 1 each: copy in progress / copy complete.

Function
REQ-018 SHALL implement FSM states IDLE, CMD, ADDR, DATA, WRITE, DONE.
REQ-019 In IDLE, start==1 SHALL move to CMD on the next edge with spi_cs=0 and busy=1; start is ignored in every other state.
REQ-020 CMD SHALL shift 8'h03 out MSB first; ADDR SHALL then shift FLASH_BASE[23:0] out MSB first; then go to DATA.
REQ-021 Bit timing: spi_clk low for CLK_DIV cycles, then high for CLK_DIV cycles; spi_mosi changes only while spi_clk is low; spi_miso is sampled on the cycle spi_clk rises.
REQ-022 DATA SHALL receive 32 bits as 4 bytes, each MSB first; the first byte received goes to wdata[7:0] and the fourth to wdata[31:24] (little-endian).
REQ-023 After bit 32, the FSM SHALL enter WRITE with imem_we=1 and imem_wdata/imem_addr stable; spi_clk is held low and spi_cs stays low (stream paused).
REQ-024 imem_we SHALL remain 1 until a cycle with imem_ready==1; the next edge drops imem_we and adds 4 to imem_addr; imem_ready==1 in the same cycle imem_we rises completes the write in one cycle.
REQ-025 After the write, if words written < WORD_COUNT the FSM returns to DATA (no new command); otherwise it enters DONE.
REQ-026 DONE SHALL drive spi_cs=1, busy=0, done=1 and cpu_hold=0; it is terminal until reset (start re-assertion is ignored).
REQ-027 spi_mosi SHALL be 0 in DATA, WRITE, IDLE and DONE.
REQ-028 Word counter SHALL be 16 bits; imem_addr SHALL wrap modulo 2^32 without error.
REQ-029 Latency from the start edge to the first imem_we SHALL be exactly 1 + 64*2*CLK_DIV cycles (32 command/address bits plus 32 data bits).

Reset
REQ-030 reset==0 SHALL, on the next edge, force IDLE with spi_cs=1, spi_clk=0, spi_mosi=0, imem_we=0, imem_addr=IMEM_BASE, imem_wdata=0, cpu_hold=1, busy=0, done=0, and clear all counters.
REQ-031 Reset during any state, including mid-bit or mid-handshake, SHALL abort immediately with no further imem_we; the next start restarts from FLASH_BASE.

Structure
REQ-032 Package flash_boot_pkg SHALL hold the state enum, READ_CMD=8'h03, and the CMD_BITS=8 / ADDR_BITS=24 / WORD_BITS=32 constants.
REQ-033 Sub-module spi_shift_engine (clock divider, bit counter, TX/RX shift registers, bit_done strobe) SHALL be instantiated once; the FSM stays in flash_boot_ctrl.

Verification
REQ-034 The flash model with CLK_DIV=4, WORD_COUNT=4 and words 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0000006F -> writes to addresses 0x0, 0x4, 0x8, 0xC carry exactly those values, then done=1 and cpu_hold=0.
REQ-035 MOSI capture on spi_clk rise -> 32 bits equal 0x03 followed by FLASH_BASE=24'h001000; first imem_we arrives 513 cycles after start.
REQ-036 imem_ready held 0 for 10 cycles -> imem_we and data stable for 10 cycles, spi_clk low throughout, no words lost.
REQ-037 Reset pulse during word 2 of DATA -> spi_cs=1 and cpu_hold=1 on the next edge, no further writes; restart recopies from imem_addr=IMEM_BASE.
REQ-038 start pulsed during DATA and again in DONE -> no state change, write count stays WORD_COUNT.
REQ-039 IMEM_BASE=32'hFFFFFFFC with WORD_COUNT=2 -> write addresses 0xFFFFFFFC then 0x00000000.
